// File: rtl/sort_compare_swap_pkg.sv
// Shared types and defaults for the selection-sort compare/swap stage.
// The SORT_DESCEND_EN macro (see sort_cmp_unit) flips the sort order.
package sort_pkg;

  localparam int SIZE_ADDR_DEF = 8;
  localparam int SIZE_DATA_DEF = 16;

  typedef enum logic [2:0] {
    IDLE,
    RD_I,
    SCAN,
    DRAIN,
    WR_I,
    WR_M,
    DONE
  } sort_cs_state_e;

endpackage

// File: rtl/sort_compare_swap_if.sv
// Array access bus between the sort engine (master) and the element store (slave).
// Signal names are from the engine's point of view.
interface sort_arr_if import sort_pkg::*; #(
  parameter int SIZE_ADDR = SIZE_ADDR_DEF,
  parameter int SIZE_DATA = SIZE_DATA_DEF
) ();

  logic [SIZE_ADDR-1:0] o_rd_addr;
  logic [SIZE_DATA-1:0] i_rd_data;
  logic                 o_wr_en;
  logic [SIZE_ADDR-1:0] o_wr_addr;
  logic [SIZE_DATA-1:0] o_wr_data;

  modport master (
    output o_rd_addr, o_wr_en, o_wr_addr, o_wr_data,
    input  i_rd_data
  );

  modport slave (
    input  o_rd_addr, o_wr_en, o_wr_addr, o_wr_data,
    output i_rd_data
  );

endinterface

// File: rtl/sort_compare_swap_cmp.sv
// Running best-element tracker: minimum by default, maximum when SORT_DESCEND_EN is defined.
// Strict compare keeps the earliest index on ties.
module sort_cmp_unit import sort_pkg::*; #(
  parameter int SIZE_ADDR = SIZE_ADDR_DEF,
  parameter int SIZE_DATA = SIZE_DATA_DEF
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_init,
  input  logic [SIZE_ADDR-1:0] i_init_idx,
  input  logic                 i_valid,
  input  logic [SIZE_ADDR-1:0] i_idx,
  input  logic [SIZE_DATA-1:0] i_data,
  output logic [SIZE_DATA-1:0] o_min_val,
  output logic [SIZE_ADDR-1:0] o_min_idx,
  output logic                 o_upd
);

  logic [SIZE_DATA-1:0] r_min_val;
  logic [SIZE_ADDR-1:0] r_min_idx;
  logic                 w_better;

`ifdef SORT_DESCEND_EN
  assign w_better = i_data > r_min_val;
`else
  assign w_better = i_data < r_min_val;
`endif

  // o_upd lets the owner see this cycle's update before it lands in the registers
  assign o_upd = i_valid & w_better;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_min_val <= '0;
      r_min_idx <= '0;
    end else if (i_init) begin
      r_min_val <= i_data;
      r_min_idx <= i_init_idx;
    end else if (o_upd) begin
      r_min_val <= i_data;
      r_min_idx <= i_idx;
    end
  end

  assign o_min_val = r_min_val;
  assign o_min_idx = r_min_idx;

endmodule

// File: rtl/sort_compare_swap.sv
// One selection-sort pass: read A[i], scan A[j] for the best element, swap A[i] with it.
// Order is ascending unless SORT_DESCEND_EN is defined.
module sort_compare_swap import sort_pkg::*; #(
  parameter int SIZE_ADDR = SIZE_ADDR_DEF,
  parameter int SIZE_DATA = SIZE_DATA_DEF
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_start,
  input  logic [SIZE_ADDR-1:0] i_value_i,
  input  logic                 i_j_valid,
  input  logic [SIZE_ADDR-1:0] i_value_j,
  input  logic                 i_j_done,
  sort_arr_if.master           arr,
  output logic                 o_busy,
  output logic [SIZE_ADDR-1:0] o_min_idx,
  output logic                 o_pass_done
);

  sort_cs_state_e       r_state;
  logic [SIZE_ADDR-1:0] r_i, r_cmp_j, r_wr_addr;
  logic [SIZE_DATA-1:0] r_val_i, r_wr_data;
  logic                 r_cmp_v, r_wr_en, r_busy, r_pass_done;

  logic [SIZE_ADDR-1:0] w_rd_addr, w_min_idx, w_fin_idx;
  logic [SIZE_DATA-1:0] w_min_val, w_fin_val;
  logic                 w_upd;

  always_comb begin
    w_rd_addr = '0;
    case (r_state)
      IDLE:    if (i_start) w_rd_addr = i_value_i;
      SCAN:    w_rd_addr = i_value_j;
      default: w_rd_addr = '0;
    endcase
  end

  sort_cmp_unit #(
    .SIZE_ADDR (SIZE_ADDR),
    .SIZE_DATA (SIZE_DATA)
  ) u_cmp (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_init     (r_state == RD_I),
    .i_init_idx (r_i),
    .i_valid    (r_cmp_v),
    .i_idx      (r_cmp_j),
    .i_data     (arr.i_rd_data),
    .o_min_val  (w_min_val),
    .o_min_idx  (w_min_idx),
    .o_upd      (w_upd)
  );

  // DRAIN decides on the result including the compare landing this same cycle
  assign w_fin_idx = w_upd ? r_cmp_j       : w_min_idx;
  assign w_fin_val = w_upd ? arr.i_rd_data : w_min_val;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state     <= IDLE;
      r_i         <= '0;
      r_val_i     <= '0;
      r_cmp_v     <= 1'b0;
      r_cmp_j     <= '0;
      r_wr_en     <= 1'b0;
      r_wr_addr   <= '0;
      r_wr_data   <= '0;
      r_busy      <= 1'b0;
      r_pass_done <= 1'b0;
    end else begin
      r_cmp_v     <= 1'b0;
      r_cmp_j     <= '0;
      r_wr_en     <= 1'b0;
      r_wr_addr   <= '0;
      r_wr_data   <= '0;
      r_pass_done <= 1'b0;
      case (r_state)
        IDLE: if (i_start) begin
          r_i     <= i_value_i;
          r_busy  <= 1'b1;
          r_state <= RD_I;
        end
        RD_I: begin
          r_val_i <= arr.i_rd_data;
          r_state <= SCAN;
        end
        SCAN: begin
          r_cmp_v <= i_j_valid;
          r_cmp_j <= i_value_j;
          if (i_j_done) r_state <= DRAIN;
        end
        DRAIN: if (w_fin_idx != r_i) begin
          r_wr_en   <= 1'b1;
          r_wr_addr <= r_i;
          r_wr_data <= w_fin_val;
          r_state   <= WR_I;
        end else begin
          r_pass_done <= 1'b1;
          r_state     <= DONE;
        end
        WR_I: begin
          r_wr_en   <= 1'b1;
          r_wr_addr <= w_min_idx;
          r_wr_data <= r_val_i;
          r_state   <= WR_M;
        end
        WR_M: begin
          r_pass_done <= 1'b1;
          r_state     <= DONE;
        end
        DONE: begin
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign arr.o_rd_addr = w_rd_addr;
  assign arr.o_wr_en   = r_wr_en;
  assign arr.o_wr_addr = r_wr_addr;
  assign arr.o_wr_data = r_wr_data;
  assign o_busy        = r_busy;
  assign o_min_idx     = w_min_idx;
  assign o_pass_done   = r_pass_done;

endmodule

// File: tb/tb_sort_compare_swap.sv
// Bench for sort_compare_swap: array store, per-pass expected trace from a plain
// best-index search, directed cases from the pass examples, and a full random sort.
module tb_sort_compare_swap;

  localparam int AW = 8;
  localparam int DW = 16;

  logic          i_clk = 1'b0, i_rst_n = 1'b0, i_start = 1'b0;
  logic          i_j_valid = 1'b0, i_j_done = 1'b0;
  logic [AW-1:0] i_value_i = '0, i_value_j = '0;
  logic          o_busy, o_pass_done;
  logic [AW-1:0] o_min_idx;

  sort_arr_if #(.SIZE_ADDR(AW), .SIZE_DATA(DW)) bus ();

  sort_compare_swap #(.SIZE_ADDR(AW), .SIZE_DATA(DW)) dut (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_start     (i_start),
    .i_value_i   (i_value_i),
    .i_j_valid   (i_j_valid),
    .i_value_j   (i_value_j),
    .i_j_done    (i_j_done),
    .arr         (bus),
    .o_busy      (o_busy),
    .o_min_idx   (o_min_idx),
    .o_pass_done (o_pass_done)
  );

  always #5 i_clk = ~i_clk;

  // element store: one-cycle read latency, bench preload port has priority
  logic [DW-1:0] mem [256];
  logic          ld_en = 1'b0;
  logic [AW-1:0] ld_addr = '0;
  logic [DW-1:0] ld_data = '0;
  always @(posedge i_clk) begin
    if (ld_en) mem[ld_addr] <= ld_data;
    else if (bus.o_wr_en) mem[bus.o_wr_addr] <= bus.o_wr_data;
    bus.i_rd_data <= mem[bus.o_rd_addr];
  end

  int total = 0, bad = 0, cyc = 0, start_cyc = 0, last_pd = -1;
  always @(posedge i_clk) cyc <= cyc + 1;

  task automatic chk(string nm, int act, int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  typedef struct {
    bit busy, wr_en, pd, chk_rd, chk_min;
    int wr_addr, wr_data, rd_addr, min_idx;
  } exp_t;
  exp_t exp_q[$];

  function automatic void push(bit busy, bit wr, bit pd, bit crd, bit cmin,
                               int wa, int wd, int ra, int mi);
    exp_t e;
    e.busy = busy; e.wr_en = wr; e.pd = pd; e.chk_rd = crd; e.chk_min = cmin;
    e.wr_addr = wa; e.wr_data = wd; e.rd_addr = ra; e.min_idx = mi;
    exp_q.push_back(e);
  endfunction

  // per-cycle compare against the expected trace of the current pass
  always @(negedge i_clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("busy",      int'(o_busy),        int'(e.busy));
      chk("wr_en",     int'(bus.o_wr_en),   int'(e.wr_en));
      chk("wr_addr",   int'(bus.o_wr_addr), e.wr_addr);
      chk("wr_data",   int'(bus.o_wr_data), e.wr_data);
      chk("pass_done", int'(o_pass_done),   int'(e.pd));
      if (e.chk_rd)  chk("rd_addr", int'(bus.o_rd_addr), e.rd_addr);
      if (e.chk_min) chk("min_idx", int'(o_min_idx), e.min_idx);
      if (o_pass_done) last_pd = cyc - start_cyc + 1;
    end
  end

  int ref_a [256];
  bit slot_v [128];
  int slot_j [128];
  int nslot;

  function automatic bit better(int a, int b);
`ifdef SORT_DESCEND_EN
    return a > b;
`else
    return a < b;
`endif
  endfunction

  task automatic ld(int a, int d);
    @(posedge i_clk); #1;
    ld_en = 1'b1; ld_addr = AW'(a); ld_data = DW'(d);
    ref_a[a] = d;
  endtask

  task automatic ld_end();
    @(posedge i_clk); #1;
    ld_en = 1'b0;
  endtask

  task automatic noise_j(bit noise);
    i_j_valid = noise ? 1'($urandom_range(0, 1)) : 1'b0;
    i_j_done  = noise ? 1'($urandom_range(0, 1)) : 1'b0;
    i_value_j = noise ? AW'($urandom_range(0, 255)) : '0;
  endtask

  // cycle 1 = the cycle i_start is high; j slots occupy cycles 3..nslot+2
  task automatic run_pass(int i, bit noise);
    int m, d, g, nm, tmp;
    bit sw;
    m = i;
    for (int s = 0; s < nslot; s++)
      if (slot_v[s] && better(ref_a[slot_j[s]], ref_a[m])) m = slot_j[s];
    d  = nslot + 2;
    sw = (m != i);
    @(posedge i_clk); #1;
    start_cyc = cyc;
    last_pd   = -1;
    push(0, 0, 0, 1, 0, 0, 0, i, 0);
    for (int c = 2; c <= d + 1; c++)
      push(1, 0, 0, (c >= 3 && c <= d), 0, 0, 0, (c >= 3 && c <= d) ? slot_j[c-3] : 0, 0);
    if (sw) begin
      push(1, 1, 0, 0, 0, i, ref_a[m], 0, 0);
      push(1, 1, 0, 0, 0, m, ref_a[i], 0, 0);
    end
    push(1, 0, 1, 0, 1, 0, 0, 0, m);
    push(0, 0, 0, 1, 1, 0, 0, 0, m);
    if (sw) begin
      tmp = ref_a[i]; ref_a[i] = ref_a[m]; ref_a[m] = tmp;
    end
    i_start = 1'b1; i_value_i = AW'(i); noise_j(noise);
    @(posedge i_clk); #1;
    i_start = noise ? 1'($urandom_range(0, 1)) : 1'b0;
    noise_j(noise);
    for (int s = 0; s < nslot; s++) begin
      @(posedge i_clk); #1;
      i_start   = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      i_j_valid = slot_v[s];
      i_value_j = AW'(slot_j[s]);
      i_j_done  = (s == nslot - 1);
    end
    g = 0;
    while (exp_q.size() > 0 && g < 64) begin
      @(posedge i_clk); #1;
      i_start = 1'b0;
      noise_j(noise);
      g++;
    end
    if (exp_q.size() > 0) begin
      chk("pass_timeout", exp_q.size(), 0);
      exp_q.delete();
    end
    i_j_valid = 1'b0; i_j_done = 1'b0; i_value_j = '0;
    nm = 0;
    for (int k = 0; k < 64; k++) if (int'(mem[k]) != ref_a[k]) nm++;
    chk("mem_state", nm, 0);
  endtask

  task automatic slots_seq(int first, int last);
    nslot = 0;
    for (int j = first; j <= last; j++) begin
      slot_v[nslot] = 1'b1; slot_j[nslot] = j; nslot++;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int e_min, e_pd, inv;
    int e_arr [4];

    // reset state
    repeat (3) @(posedge i_clk);
    @(negedge i_clk);
    chk("rst_busy",    int'(o_busy), 0);
    chk("rst_pd",      int'(o_pass_done), 0);
    chk("rst_wr_en",   int'(bus.o_wr_en), 0);
    chk("rst_wr_addr", int'(bus.o_wr_addr), 0);
    chk("rst_wr_data", int'(bus.o_wr_data), 0);
    chk("rst_min_idx", int'(o_min_idx), 0);
    chk("rst_rd_addr", int'(bus.o_rd_addr), 0);
    @(posedge i_clk); #1;
    i_rst_n = 1'b1;

    for (int k = 0; k < 64; k++) ld(k, int'($urandom_range(0, 15)));
    ld_end();

    // A = [5,3,8,1], back-to-back j = 1..3
    ld(0, 5); ld(1, 3); ld(2, 8); ld(3, 1); ld_end();
    slots_seq(1, 3);
    run_pass(0, 1'b0);
`ifdef SORT_DESCEND_EN
    e_min = 2; e_arr = '{8, 3, 5, 1};
`else
    e_min = 3; e_arr = '{1, 3, 8, 5};
`endif
    chk("t1_min_idx", int'(o_min_idx), e_min);
    chk("t1_pd_cycle", last_pd, 9);
    for (int k = 0; k < 4; k++) chk("t1_array", int'(mem[k]), e_arr[k]);

    // A = [1,4,6]
    ld(0, 1); ld(1, 4); ld(2, 6); ld_end();
    slots_seq(1, 2);
    run_pass(0, 1'b0);
`ifdef SORT_DESCEND_EN
    e_min = 2; e_pd = 8;
`else
    e_min = 0; e_pd = 6;
`endif
    chk("t2_min_idx", int'(o_min_idx), e_min);
    chk("t2_pd_cycle", last_pd, e_pd);

    // A = [2,7,2] tie on the extremes
    ld(0, 2); ld(1, 7); ld(2, 2); ld_end();
    slots_seq(1, 2);
    run_pass(0, 1'b0);
`ifdef SORT_DESCEND_EN
    e_min = 1; e_arr = '{7, 2, 2, 0};
`else
    e_min = 0; e_arr = '{2, 7, 2, 0};
`endif
    chk("t3_min_idx", int'(o_min_idx), e_min);
    for (int k = 0; k < 3; k++) chk("t3_array", int'(mem[k]), e_arr[k]);

    // A = [9,2,5,1] with gaps in the j stream and stray start/j pulses
    ld(0, 9); ld(1, 2); ld(2, 5); ld(3, 1); ld_end();
    nslot = 6;
    slot_v = '{default: 1'b0};
    slot_v[0] = 1'b1; slot_j[0] = 1;
    slot_j[1] = 77;
    slot_v[2] = 1'b1; slot_j[2] = 2;
    slot_j[3] = 40; slot_j[4] = 41;
    slot_v[5] = 1'b1; slot_j[5] = 3;
    run_pass(0, 1'b1);
`ifdef SORT_DESCEND_EN
    e_min = 0; e_pd = 10;
`else
    e_min = 3; e_pd = 12;
`endif
    chk("t4_min_idx", int'(o_min_idx), e_min);
    chk("t4_pd_cycle", last_pd, e_pd);

    // empty j range
    nslot = 1; slot_v[0] = 1'b0; slot_j[0] = 6;
    run_pass(5, 1'b0);
    chk("t5_min_idx", int'(o_min_idx), 5);
    chk("t5_pd_cycle", last_pd, 5);

    // reset during SCAN
    ld(2, 9); ld(3, 1); ld(4, 4); ld(5, 0); ld_end();
    @(posedge i_clk); #1; i_start = 1'b1; i_value_i = AW'(2);
    @(posedge i_clk); #1; i_start = 1'b0;
    @(posedge i_clk); #1; i_j_valid = 1'b1; i_value_j = AW'(3);
    @(posedge i_clk); #1; i_value_j = AW'(4); i_rst_n = 1'b0;
    @(negedge i_clk);
    chk("mid_busy_pre", int'(o_busy), 1);
    chk("mid_min_pre",  int'(o_min_idx), 2);
    @(posedge i_clk); #1; i_rst_n = 1'b1; i_value_j = AW'(7);
    @(negedge i_clk);
    chk("mid_busy",    int'(o_busy), 0);
    chk("mid_pd",      int'(o_pass_done), 0);
    chk("mid_wr_en",   int'(bus.o_wr_en), 0);
    chk("mid_wr_addr", int'(bus.o_wr_addr), 0);
    chk("mid_wr_data", int'(bus.o_wr_data), 0);
    chk("mid_min_idx", int'(o_min_idx), 0);
    chk("mid_rd_addr", int'(bus.o_rd_addr), 0);
    @(posedge i_clk); #1; i_j_valid = 1'b0; i_value_j = '0;
    repeat (6) @(posedge i_clk);
    inv = 0;
    for (int k = 0; k < 64; k++) if (int'(mem[k]) != ref_a[k]) inv++;
    chk("mid_no_writes", inv, 0);
    slots_seq(3, 5);
    run_pass(2, 1'b0);
`ifdef SORT_DESCEND_EN
    e_min = 2;
`else
    e_min = 5;
`endif
    chk("mid_after_min", int'(o_min_idx), e_min);

    // full random sort of A[0..23] with gapped j streams
    for (int k = 0; k < 24; k++) ld(k, int'($urandom_range(0, 15)));
    ld_end();
    for (int i = 0; i < 23; i++) begin
      nslot = 0;
      for (int j = i + 1; j < 24; j++) begin
        for (int gp = int'($urandom_range(0, 2)); gp > 0; gp--) begin
          slot_v[nslot] = 1'b0; slot_j[nslot] = int'($urandom_range(0, 255)); nslot++;
        end
        slot_v[nslot] = 1'b1; slot_j[nslot] = j; nslot++;
      end
      if ($urandom_range(0, 3) == 0) begin
        slot_v[nslot] = 1'b0; slot_j[nslot] = 0; nslot++;
      end
      run_pass(i, 1'b1);
    end
    inv = 0;
    for (int k = 0; k < 23; k++)
`ifdef SORT_DESCEND_EN
      if (mem[k] < mem[k+1]) inv++;
`else
      if (mem[k] > mem[k+1]) inv++;
`endif
    chk("sorted_order", inv, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
